// File: rtl/fp32_tap_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : fp32_tap_accumulator
// Brief    : Serial fp32 reduction controller. Folds N_TAPS signed tap
//            products into an accumulator through an external shared fp32
//            adder, then presents the sum on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module fp32_tap_accumulator #(
    parameter int N_TAPS  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rstn,
    // product stream
    input  logic [31:0] s_data,
    input  logic        s_op,
    input  logic        s_valid,
    output logic        s_ready,
    // shared adder interface
    output logic [31:0] add_dina,
    output logic [31:0] add_dinb,
    output logic        add_op,
    output logic        add_valid_in,
    input  logic [31:0] add_result,
    input  logic        add_valid_out,
    // reduced sum
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        err
);

    localparam int CW = $clog2(N_TAPS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_N_TAPS   = CW'(N_TAPS);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TAKE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    state_t         r_state;
    logic [31:0]    r_acc;
    logic [CW-1:0]  r_tap_cnt;
    logic [TW-1:0]  r_tmo;
    logic           r_s_ready;
    logic [31:0]    r_dina;
    logic [31:0]    r_dinb;
    logic           r_op;
    logic           r_vin;
    logic [31:0]    r_m_data;
    logic           r_m_valid;
    logic           r_err;
    logic           r_vout_d;

    logic           w_accept;
    logic           w_res_edge;

    // A product is consumed only on a real handshake; the adder result is
    // taken only on the rising edge of its valid so a held-high valid is
    // seen exactly once.
    assign w_accept   = s_valid & r_s_ready;
    assign w_res_edge = add_valid_out & ~r_vout_d;

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_tap_cnt <= '0;
            r_tmo     <= '0;
            r_s_ready <= 1'b0;
            r_dina    <= '0;
            r_dinb    <= '0;
            r_op      <= 1'b0;
            r_vin     <= 1'b0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_err     <= 1'b0;
            r_vout_d  <= 1'b0;
        end else begin
            r_vout_d <= add_valid_out;
            case (r_state)
                ST_IDLE: begin
                    r_s_ready <= 1'b1;
                    if (w_accept) begin
                        // First product enters the accumulator directly;
                        // subtraction is an exact sign flip.
                        r_acc     <= {s_data[31] ^ s_op, s_data[30:0]};
                        r_tap_cnt <= CW'(1);
                        r_state   <= ST_TAKE;
                    end
                end
                ST_TAKE: begin
                    if (w_accept) begin
                        r_dina    <= r_acc;
                        r_dinb    <= s_data;
                        r_op      <= s_op;
                        r_tap_cnt <= r_tap_cnt + CW'(1);
                        r_s_ready <= 1'b0;
                        r_vin     <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_vin   <= 1'b0;
                    r_tmo   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_res_edge) begin
                        r_acc <= add_result;
                        if (r_tap_cnt == C_N_TAPS) begin
                            r_m_data  <= add_result;
                            r_m_valid <= 1'b1;
                            r_state   <= ST_OUT;
                        end else begin
                            r_s_ready <= 1'b1;
                            r_state   <= ST_TAKE;
                        end
                    end else if (r_tmo == C_TMO_LAST) begin
                        // Adder never answered: drop this sample.
                        r_err     <= 1'b1;
                        r_acc     <= '0;
                        r_tap_cnt <= '0;
                        r_s_ready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_tap_cnt <= '0;
                        r_s_ready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready      = r_s_ready;
    assign add_dina     = r_dina;
    assign add_dinb     = r_dinb;
    assign add_op       = r_op;
    assign add_valid_in = r_vin;
    assign m_data       = r_m_data;
    assign m_valid      = r_m_valid;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fp32_tap_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_tap_accumulator
// Brief    : Directed bench for fp32_tap_accumulator with a behavioural
//            fp32 adder of configurable latency / valid hold / drop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_tap_accumulator;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] s_data;
    logic        s_op;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] add_dina;
    logic [31:0] add_dinb;
    logic        add_op;
    logic        add_valid_in;
    logic [31:0] add_result;
    logic        add_valid_out;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    fp32_tap_accumulator #(.N_TAPS(8), .TIMEOUT(64)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .s_data       (s_data),
        .s_op         (s_op),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .add_dina     (add_dina),
        .add_dinb     (add_dinb),
        .add_op       (add_op),
        .add_valid_in (add_valid_in),
        .add_result   (add_result),
        .add_valid_out(add_valid_out),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .err          (err)
    );

    always #5 clk = ~clk;

    // ---------------- fp32 helpers for the adder model ----------------
    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real         a;
        int          e;
        logic        s;
        logic [22:0] mt;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        mt = 23'($rtoi((a - 1.0) * 8388608.0));
        return {s, 8'(e + 127), mt};
    endfunction

    // ---------------- adder model (drives on negedge) ----------------
    logic        model_en  = 1'b1;
    int          lat       = 3;
    int          hold      = 1;
    int          drop_from = 0;
    int          n_issue   = 0;
    int          max_w     = 0;
    int          cur_w     = 0;
    int          cnt       = 0;
    int          hcnt      = 0;
    logic [31:0] pend      = 32'h0;
    logic [31:0] first_dina = 32'h0;

    always @(negedge clk) begin
        if (model_en) begin
            if (hcnt > 0) begin
                hcnt--;
                if (hcnt == 0) add_valid_out = 1'b0;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    add_result    = pend;
                    add_valid_out = 1'b1;
                    hcnt          = hold;
                end
            end
            if (add_valid_in) begin
                cur_w++;
                if (cur_w > max_w) max_w = cur_w;
                if (cur_w == 1) begin
                    n_issue++;
                    if (n_issue == 1) first_dina = add_dina;
                    if (!(drop_from > 0 && n_issue >= drop_from)) begin
                        pend = add_op ? r2f(f2r(add_dina) - f2r(add_dinb))
                                      : r2f(f2r(add_dina) + f2r(add_dinb));
                        cnt  = lat;
                    end
                end
            end else begin
                cur_w = 0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Present one product and hold it until consumed; returns at a negedge.
    task automatic push(input logic [31:0] d, input logic op);
        int n = 0;
        s_data  = d;
        s_op    = op;
        s_valid = 1'b1;
        while (!s_ready && n < 300) begin @(negedge clk); n++; end
        check_eq("push_ready", 32'(n < 300), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic burst(input logic [31:0] p0, input logic op0,
                         input logic [31:0] p, input logic op, input int n);
        push(p0, op0);
        for (int i = 1; i < n; i++) push(p, op);
    endtask

    task automatic wait_out(input string tag, output logic [31:0] d);
        int n = 0;
        while (!m_valid && n < 3000) begin @(negedge clk); n++; end
        check_eq(tag, 32'(m_valid), 32'd1);
        d = m_data;
    endtask

    task automatic reset_model();
        n_issue = 0;
        max_w   = 0;
        cur_w   = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] d;
    int          bad;
    int          k;
    int          seen_mv;

    initial begin
        rstn          = 1'b0;
        s_data        = 32'h0;
        s_op          = 1'b0;
        s_valid       = 1'b0;
        m_ready       = 1'b1;
        add_result    = 32'h0;
        add_valid_out = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_s_ready", 32'(s_ready), 32'd0);
        check_eq("rst_vin", 32'(add_valid_in), 32'd0);
        check_eq("rst_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_m_data", m_data, 32'h0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_dina", add_dina, 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        // 1: eight times 1.0
        reset_model();
        burst(32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 8);
        wait_out("s1_valid", d);
        check_eq("s1_sum", d, 32'h41000000);
        @(negedge clk);
        check_eq("s1_issues", 32'(n_issue), 32'd7);
        check_eq("s1_pulse_w", 32'(max_w), 32'd1);

        // 2: -2.0 then seven +0.5
        reset_model();
        burst(32'h40000000, 1'b1, 32'h3F000000, 1'b0, 8);
        wait_out("s2_valid", d);
        check_eq("s2_sum", d, 32'h3FC00000);
        check_eq("s2_first_acc", first_dina, 32'hC0000000);
        @(negedge clk);

        // 3: valid_out held 4 cycles
        reset_model();
        hold = 4;
        burst(32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 8);
        wait_out("s3_valid", d);
        check_eq("s3_sum", d, 32'h41000000);
        @(negedge clk);
        check_eq("s3_issues", 32'(n_issue), 32'd7);
        hold = 1;

        // 4: backpressure in OUT
        reset_model();
        m_ready = 1'b0;
        burst(32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 8);
        wait_out("s4_valid", d);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!m_valid || m_data !== 32'h41000000 || s_ready || add_valid_in) bad++;
            @(negedge clk);
        end
        check_eq("s4_stable", 32'(bad), 32'd0);
        check_eq("s4_issues", 32'(n_issue), 32'd7);
        m_ready = 1'b1;
        @(negedge clk);
        check_eq("s4_mv_drop", 32'(m_valid), 32'd0);
        check_eq("s4_idle_ready", 32'(s_ready), 32'd1);

        // 5: adder stops answering at the third issue
        reset_model();
        drop_from = 3;
        burst(32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 4);
        check_eq("s5_issue3", 32'(add_valid_in), 32'd1);
        k = 0;
        seen_mv = 0;
        while (!err && k < 200) begin
            @(negedge clk);
            k++;
            if (m_valid) seen_mv++;
        end
        check_eq("s5_tmo_cycles", 32'(k), 32'd65);
        check_eq("s5_err", 32'(err), 32'd1);
        check_eq("s5_no_mvalid", 32'(seen_mv), 32'd0);
        check_eq("s5_idle_ready", 32'(s_ready), 32'd1);
        drop_from = 0;
        reset_model();
        burst(32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 8);
        wait_out("s5b_valid", d);
        check_eq("s5b_sum", d, 32'h41000000);
        check_eq("s5b_err_sticky", 32'(err), 32'd1);
        @(negedge clk);

        // 6: reset pulse in WAIT_RES followed by a stray valid edge
        reset_model();
        push(32'h3F800000, 1'b0);
        push(32'h3F800000, 1'b0);
        @(negedge clk);
        model_en      = 1'b0;
        cnt           = 0;
        hcnt          = 0;
        add_valid_out = 1'b0;
        rstn          = 1'b0;
        @(negedge clk);
        check_eq("s6_rst_s_ready", 32'(s_ready), 32'd0);
        check_eq("s6_rst_dina", add_dina, 32'h0);
        check_eq("s6_rst_dinb", add_dinb, 32'h0);
        check_eq("s6_rst_err", 32'(err), 32'd0);
        check_eq("s6_rst_m_data", m_data, 32'h0);
        rstn = 1'b1;
        @(negedge clk);
        add_result    = 32'h12345678;
        add_valid_out = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (m_valid || add_valid_in || err) bad++;
        end
        add_valid_out = 1'b0;
        @(negedge clk);
        check_eq("s6_stray_ignored", 32'(bad), 32'd0);
        check_eq("s6_acc_clear", m_data, 32'h0);
        model_en = 1'b1;
        reset_model();
        burst(32'h3F800000, 1'b0, 32'h40000000, 1'b1, 8);
        wait_out("s6_valid", d);
        check_eq("s6_sum", d, 32'hC1500000);
        check_eq("s6_first_acc", first_dina, 32'h3F800000);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
